// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word requests into aligned word accesses on
// the data memory port. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WRITE, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic        accept, bad_f3, misalign, req_err;
  logic [31:0] byte_sh, half_sh, load_data, lane_mask, lane_data, merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    bad_f3   = req_we ? (req_funct3 > 3'b010)
                      : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0] = 01 covers LH/LHU/SH, 10 covers LW/SW
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b0;
    endcase
`endif
    req_err = bad_f3 | misalign;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (state_nxt == RD_WAIT || state_nxt == RMW_RD)
          cnt <= 4'(READ_LATENCY);
      end else if (state == RD_WAIT || state == RMW_RD) begin
        if (cnt != 4'd0)
          cnt <= cnt - 4'd1;
        if (cnt <= 4'd1)
          word_q <= mem_rd;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                     state_nxt = RESP;
          else if (!req_we)                state_nxt = RD_WAIT;
          else if (req_funct3[1:0] == 2'b10) state_nxt = WRITE;
          else                             state_nxt = RMW_RD;
        end
      end
      RD_WAIT: if (cnt <= 4'd1) state_nxt = RESP;
      RMW_RD:  if (cnt <= 4'd1) state_nxt = RMW_WR;
      WRITE:   state_nxt = RESP;
      RMW_WR:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    byte_sh = word_q >> {addr_q[1:0], 3'b000};
    half_sh = word_q >> {addr_q[1], 4'b0000};
    case (f3_q)
      3'b000:  load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_data = {24'd0, byte_sh[7:0]};
      3'b001:  load_data = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  load_data = {16'd0, half_sh[15:0]};
      default: load_data = word_q;
    endcase
    if (f3_q[1:0] == 2'b00) begin
      lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      lane_data = {4{wdata_q[7:0]}};
    end else begin
      lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      lane_data = {2{wdata_q[15:0]}};
    end
    merged = (word_q & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    mem_a     = 32'd0;
    mem_wd    = 32'd0;
    mem_we    = 1'b0;
    case (state)
      RD_WAIT, RMW_RD: mem_a = {addr_q[31:2], 2'b00};
      WRITE: begin
        mem_a  = {addr_q[31:2], 2'b00};
        mem_wd = wdata_q;
        mem_we = 1'b1;
      end
      RMW_WR: begin
        mem_a  = {addr_q[31:2], 2'b00};
        mem_wd = merged;
        mem_we = 1'b1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || we_q) ? 32'd0 : load_data;
      end
      default: ;
    endcase
  end

endmodule
